// File: rtl/median_pkg.sv
// Shared types and constants for the triangle-median engine.
// Optional square-root stage is enabled by defining MEDIAN_SQRT_EN.
package median_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_DIFF,
        PH_SQX,
        PH_SQY,
        PH_ROOT
    } phase_e;

    localparam logic [1:0] MED_AD = 2'd0;
    localparam logic [1:0] MED_BE = 2'd1;
    localparam logic [1:0] MED_CF = 2'd2;

    // 4*|median|^2 for W-bit signed points needs 2W+4 unsigned bits.
    function automatic int res_width(input int w);
        return 2 * w + 4;
    endfunction

endpackage

// File: rtl/median_isqrt.sv
// Restoring bit-serial integer square root, one result bit per cycle.
// Only built when MEDIAN_SQRT_EN is defined.
`ifdef MEDIAN_SQRT_EN
module median_isqrt
    import median_pkg::*;
#(
    parameter  int W     = 8,
    localparam int RES_W = res_width(W),
    localparam int CW    = $clog2(W + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [RES_W-1:0] rad_i,
    output logic             done_o,
    output logic [W+1:0]     root_o
);

    logic [RES_W-1:0] rad_q, rad_d;
    logic [W+2:0]     rem_q, rem_d;
    logic [W+1:0]     root_q, root_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [W+4:0]     rem_sh;
    logic [W+3:0]     trial;
    logic             ge;

    // Remainder never exceeds 2*root, so W+3 bits hold it between steps.
    always_comb begin
        rem_sh = {rem_q, rad_q[RES_W-1 -: 2]};
        trial  = {root_q, 2'b01};
        ge     = (rem_sh >= {1'b0, trial});
        rem_d  = ge ? (W+3)'(rem_sh - {1'b0, trial}) : (W+3)'(rem_sh);
        root_d = {root_q[W:0], ge};
        rad_d  = rad_q << 2;
        cnt_d  = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= '0;
        end else if (start_i) begin
            rad_q  <= rad_i;
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CW'(W + 2);
        end else if (cnt_q != '0) begin
            rad_q  <= rad_d;
            rem_q  <= rem_d;
            root_q <= root_d;
            cnt_q  <= cnt_d;
        end
    end

    // done marks the cycle whose edge completes the last bit; root_o is that final value.
    assign done_o = (cnt_q == CW'(1));
    assign root_o = root_d;

endmodule
`endif

// File: rtl/median_seq.sv
// Sequenced triangle-median engine on one shared signed multiplier.
// Define MEDIAN_SQRT_EN to add the ROOT phase and len_* outputs.
module median_seq
    import median_pkg::*;
#(
    parameter  int W     = 8,
    localparam int RES_W = res_width(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] ax,
    input  logic signed [W-1:0] ay,
    input  logic signed [W-1:0] bx,
    input  logic signed [W-1:0] by,
    input  logic signed [W-1:0] cx,
    input  logic signed [W-1:0] cy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    sq_ad,
    output logic [RES_W-1:0]    sq_be,
    output logic [RES_W-1:0]    sq_cf,
`ifdef MEDIAN_SQRT_EN
    output logic [W:0]          len_ad,
    output logic [W:0]          len_be,
    output logic [W:0]          len_cf,
`endif
    output logic                busy
);

    state_e state_q, state_d;
    phase_e phase_q, phase_d;
    logic [1:0] med_q, med_d;

    logic signed [W-1:0] ax_q, ay_q, bx_q, by_q, cx_q, cy_q;
    logic signed [W+1:0] dx_q, dy_q, dx_d, dy_d;
    logic [RES_W-1:0]    acc_q;
    logic [RES_W-1:0]    sq_ad_q, sq_be_q, sq_cf_q;

    logic cap_en, diff_en, sqx_en, sq_we, adv;

    logic signed [W-1:0] pm_x, pa_x, pb_x, pm_y, pa_y, pb_y;
    logic signed [W+1:0] mul_op;
    logic signed [RES_W-1:0] mul_ext, prod;
    logic [RES_W-1:0] sq_sum;

`ifdef MEDIAN_SQRT_EN
    logic [W:0]   len_ad_q, len_be_q, len_cf_q;
    logic         len_we;
    logic         root_done;
    logic [W+1:0] root_w;
    logic [W:0]   len_d;
`endif

    // 2*pm - pa - pb in W+2 bits; range is +-(4*2^(W-1)-2), so it is exact.
    function automatic logic signed [W+1:0] med_diff(
        input logic signed [W-1:0] pm,
        input logic signed [W-1:0] pa,
        input logic signed [W-1:0] pb
    );
        logic signed [W+1:0] m2, a2, b2;
        m2 = {pm[W-1], pm, 1'b0};
        a2 = {{2{pa[W-1]}}, pa};
        b2 = {{2{pb[W-1]}}, pb};
        return m2 - a2 - b2;
    endfunction

    always_comb begin
        pm_x = ax_q; pa_x = bx_q; pb_x = cx_q;
        pm_y = ay_q; pa_y = by_q; pb_y = cy_q;
        case (med_q)
            MED_BE: begin
                pm_x = bx_q; pa_x = ax_q; pb_x = cx_q;
                pm_y = by_q; pa_y = ay_q; pb_y = cy_q;
            end
            MED_CF: begin
                pm_x = cx_q; pa_x = ax_q; pb_x = bx_q;
                pm_y = cy_q; pa_y = ay_q; pb_y = by_q;
            end
            default: ;
        endcase
        dx_d = med_diff(pm_x, pa_x, pb_x);
        dy_d = med_diff(pm_y, pa_y, pb_y);
    end

    // Single squarer: SQX squares dx, SQY squares dy; the operand is muxed, not the multiplier.
    assign mul_op  = (phase_q == PH_SQY) ? dy_q : dx_q;
    assign mul_ext = {{(RES_W-W-2){mul_op[W+1]}}, mul_op};
    assign prod    = mul_ext * mul_ext;
    assign sq_sum  = acc_q + prod;

`ifdef MEDIAN_SQRT_EN
    median_isqrt #(.W(W)) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .start_i (sq_we),
        .rad_i   (sq_sum),
        .done_o  (root_done),
        .root_o  (root_w)
    );

    // floor(sqrt(4*m^2)) >> 1 == floor(m)
    assign len_d = (W+1)'(root_w >> 1);
`endif

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        med_d   = med_q;
        cap_en  = 1'b0;
        diff_en = 1'b0;
        sqx_en  = 1'b0;
        sq_we   = 1'b0;
        adv     = 1'b0;
`ifdef MEDIAN_SQRT_EN
        len_we  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_en  = 1'b1;
                    state_d = ST_CALC;
                    phase_d = PH_DIFF;
                    med_d   = MED_AD;
                end
            end
            ST_CALC: begin
                case (phase_q)
                    PH_DIFF: begin
                        diff_en = 1'b1;
                        phase_d = PH_SQX;
                    end
                    PH_SQX: begin
                        sqx_en  = 1'b1;
                        phase_d = PH_SQY;
                    end
                    PH_SQY: begin
                        sq_we = 1'b1;
`ifdef MEDIAN_SQRT_EN
                        phase_d = PH_ROOT;
`else
                        adv = 1'b1;
`endif
                    end
`ifdef MEDIAN_SQRT_EN
                    PH_ROOT: begin
                        if (root_done) begin
                            len_we = 1'b1;
                            adv    = 1'b1;
                        end
                    end
`endif
                    default: phase_d = PH_DIFF;
                endcase
                if (adv) begin
                    phase_d = PH_DIFF;
                    if (med_q == MED_CF) begin
                        state_d = ST_DONE;
                    end else begin
                        med_d = med_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= PH_DIFF;
            med_q   <= MED_AD;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            med_q   <= med_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ax_q    <= '0;
            ay_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            acc_q   <= '0;
            sq_ad_q <= '0;
            sq_be_q <= '0;
            sq_cf_q <= '0;
        end else begin
            if (cap_en) begin
                ax_q <= ax;
                ay_q <= ay;
                bx_q <= bx;
                by_q <= by;
                cx_q <= cx;
                cy_q <= cy;
            end
            if (diff_en) begin
                dx_q <= dx_d;
                dy_q <= dy_d;
            end
            if (sqx_en) begin
                acc_q <= prod;
            end
            if (sq_we) begin
                case (med_q)
                    MED_AD:  sq_ad_q <= sq_sum;
                    MED_BE:  sq_be_q <= sq_sum;
                    default: sq_cf_q <= sq_sum;
                endcase
            end
        end
    end

`ifdef MEDIAN_SQRT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_ad_q <= '0;
            len_be_q <= '0;
            len_cf_q <= '0;
        end else if (len_we) begin
            case (med_q)
                MED_AD:  len_ad_q <= len_d;
                MED_BE:  len_be_q <= len_d;
                default: len_cf_q <= len_d;
            endcase
        end
    end

    assign len_ad = len_ad_q;
    assign len_be = len_be_q;
    assign len_cf = len_cf_q;
`endif

    // in_ready is gated by rst so nothing is offered while reset is asserted.
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign sq_ad     = sq_ad_q;
    assign sq_be     = sq_be_q;
    assign sq_cf     = sq_cf_q;

endmodule

// File: tb/tb_median_seq.sv
// Directed bench for median_seq; len_* checks are active when MEDIAN_SQRT_EN is defined.
module tb_median_seq;

    localparam int W     = 8;
    localparam int RES_W = 2 * W + 4;
`ifdef MEDIAN_SQRT_EN
    localparam int LAT = 39;
`else
    localparam int LAT = 9;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] ax, ay, bx, by, cx, cy;
    logic                out_valid;
    logic                out_ready;
    logic [RES_W-1:0]    sq_ad, sq_be, sq_cf;
`ifdef MEDIAN_SQRT_EN
    logic [W:0]          len_ad, len_be, len_cf;
`endif
    logic                busy;

    int checks = 0;
    int errors = 0;

    median_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ax        (ax),
        .ay        (ay),
        .bx        (bx),
        .by        (by),
        .cx        (cx),
        .cy        (cy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sq_ad     (sq_ad),
        .sq_be     (sq_be),
        .sq_cf     (sq_cf),
`ifdef MEDIAN_SQRT_EN
        .len_ad    (len_ad),
        .len_be    (len_be),
        .len_cf    (len_cf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic drive_tri(input int pax, input int pay, input int pbx,
                             input int pby, input int pcx, input int pcy);
        ax = W'(pax); ay = W'(pay);
        bx = W'(pbx); by = W'(pby);
        cx = W'(pcx); cy = W'(pcy);
    endtask

    // Called at a negedge with coordinates already driven; returns at the negedge after the accept edge.
    task automatic accept(input string tag);
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 200);
        chk({tag, "_latency"}, n, LAT);
    endtask

    task automatic check_res(input string tag, input int e_ad, input int e_be, input int e_cf,
                             input int l_ad, input int l_be, input int l_cf);
        chk({tag, "_sq_ad"}, sq_ad, e_ad);
        chk({tag, "_sq_be"}, sq_be, e_be);
        chk({tag, "_sq_cf"}, sq_cf, e_cf);
        chk({tag, "_in_ready_done"}, in_ready, 0);
`ifdef MEDIAN_SQRT_EN
        chk({tag, "_len_ad"}, len_ad, l_ad);
        chk({tag, "_len_be"}, len_be, l_be);
        chk({tag, "_len_cf"}, len_cf, l_cf);
`else
        if (l_ad + l_be + l_cf < 0) $display("unused lens");
`endif
        $display("txn %s sq=%0d,%0d,%0d out_valid=%0b", tag, sq_ad, sq_be, sq_cf, out_valid);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_rel_out_valid"}, out_valid, 0);
        chk({tag, "_rel_in_ready"}, in_ready, 1);
        chk({tag, "_rel_busy"}, busy, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_tri(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sq_ad", sq_ad, 0);
        chk("rst_sq_cf", sq_cf, 0);
        rst = 1'b0;

        // 1: generic triangle, also latency
        drive_tri(1, -1, -4, 6, -3, -5);
        accept("t1");
        wait_out("t1");
        check_res("t1", 90, 360, 234, 4, 9, 7);
        release_out("t1");

        // 2: extreme coordinates
        drive_tri(-128, -128, 127, 127, 127, 127);
        accept("t2");
        wait_out("t2");
        check_res("t2", 520200, 130050, 130050, 360, 180, 180);

        // 4: stall in DONE while offering new data
        drive_tri(1, -1, -4, 6, -3, -5);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1 || i == 2);
            #1;
            chk("t4_in_ready", in_ready, 0);
            @(posedge clk);
            @(negedge clk);
            chk("t4_out_valid", out_valid, 1);
            chk("t4_sq_ad", sq_ad, 520200);
            chk("t4_sq_be", sq_be, 130050);
        end
        in_valid = 1'b0;
        release_out("t4");
        @(posedge clk);
        @(negedge clk);
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_sq_ad", sq_ad, 520200);
        $display("txn t4 stall done busy=%0b", busy);

        // 3: degenerate triangle
        drive_tri(5, 5, 5, 5, 5, 5);
        accept("t3");
        wait_out("t3");
        check_res("t3", 0, 0, 0, 0, 0, 0);
        release_out("t3");

        // 5: reset in the middle of CALC
        drive_tri(1, -1, -4, 6, -3, -5);
        accept("t5");
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 0);
        chk("t5_sq_ad", sq_ad, 0);
        chk("t5_sq_be", sq_be, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rel_in_ready", in_ready, 1);
        $display("txn t5 reset mid-calc busy=%0b", busy);
        @(negedge clk);
        accept("t5r");
        wait_out("t5r");
        check_res("t5r", 90, 360, 234, 4, 9, 7);
        release_out("t5r");

        // 6: back-to-back with out_ready tied high
        out_ready = 1'b1;
        drive_tri(1, -1, -4, 6, -3, -5);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive_tri(-128, -128, 127, 127, 127, 127);
        wait_out("t6a");
        check_res("t6a", 90, 360, 234, 4, 9, 7);
        @(posedge clk);
        @(negedge clk);
        chk("t6_gap_out_valid", out_valid, 0);
        chk("t6_gap_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6b_busy", busy, 1);
        wait_out("t6b");
        check_res("t6b", 520200, 130050, 130050, 360, 180, 180);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t6_end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
